// File: rtl/dut_seq_pkg.sv
// Shared encodings for the DUT vector sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dut_seq_pkg;

  // Per-pin waveform format, stored as {f1,f0} across two load planes.
  typedef enum logic [1:0] {
    FMT_NRZ = 2'b00,
    FMT_RZ  = 2'b01,
    FMT_R1  = 2'b10,
    FMT_SBC = 2'b11
  } fmt_e;

  // Targets selected by LOAD_SEL.
  typedef enum logic [1:0] {
    SEL_VEC  = 2'd0,
    SEL_FMT0 = 2'd1,
    SEL_FMT1 = 2'd2,
    SEL_OE   = 2'd3
  } load_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEF_N_PINS = 126;
  localparam int DEF_TW     = 10;
  localparam int DEF_CW     = 16;

endpackage

// File: rtl/dut_pin_fmt.sv
// One pin's waveform formatter: applies t=0 / LE / TE actions for its format code.
// Latency: an event strobe in clock k is visible on q after the next clock edge.
// Backpressure: none; events are applied every clock they are strobed.
// Ports: clk, rst_n (async active-low), d (active data bit), fmt (format code),
//        t0_ev/le_ev/te_ev (phase event strobes), q (registered pin bit).
module dut_pin_fmt
  import dut_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  fmt_e fmt,
  input  logic t0_ev,
  input  logic le_ev,
  input  logic te_ev,
  output logic q
);

  logic q_q, q_d;

  // Actions are applied in phase order so the trailing edge wins when LE = TE.
  always_comb begin
    q_d = q_q;
    if (t0_ev && fmt == FMT_SBC) q_d = ~d;
    if (le_ev) q_d = d;
    if (te_ev) begin
      case (fmt)
        FMT_RZ:  q_d = 1'b0;
        FMT_R1:  q_d = 1'b1;
        FMT_SBC: q_d = ~d;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dut_vector_sequencer.sv
// DUT pin sequencer: static format/drive-enable planes, double-buffered vectors, timed test cycles.
// Latency: pin event at phase t=k appears on PIN_OUT after the clock edge ending phase k.
// Backpressure: VEC_READY low while staging is full; a vector LOAD then is dropped and flags OVERFLOW.
// Ports: CLK, RST (async active-low); host load bus BUS/LOAD/LOAD_SEL/VEC_READY;
//        timing LEADING_EDGE/TRAILING_EDGE/CYCLE_LENGTH/NUM_CYCLES; control START/STOP;
//        PIN_OUT/PIN_OE to pad drivers; status BUSY/DONE/CYCLE_CNT/UNDERRUN/OVERFLOW/CFG_ERR.
//        Macro DUTSEQ_CAPTURE_EN adds PIN_IN/STROBE_EDGE inputs and FAIL/FAIL_MASK compare results.
module dut_vector_sequencer
  import dut_seq_pkg::*;
#(
  parameter int N_PINS = DEF_N_PINS,
  parameter int TW     = DEF_TW,
  parameter int CW     = DEF_CW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_PINS-1:0] BUS,
  input  logic              LOAD,
  input  logic [1:0]        LOAD_SEL,
  output logic              VEC_READY,
  input  logic [TW-1:0]     LEADING_EDGE,
  input  logic [TW-1:0]     TRAILING_EDGE,
  input  logic [TW-1:0]     CYCLE_LENGTH,
  input  logic [CW-1:0]     NUM_CYCLES,
  input  logic              START,
  input  logic              STOP,
  output logic [N_PINS-1:0] PIN_OUT,
  output logic [N_PINS-1:0] PIN_OE,
  output logic              BUSY,
  output logic              DONE,
  output logic [CW-1:0]     CYCLE_CNT,
  output logic              UNDERRUN,
  output logic              OVERFLOW,
  output logic              CFG_ERR
`ifdef DUTSEQ_CAPTURE_EN
  ,
  input  logic [N_PINS-1:0] PIN_IN,
  input  logic [TW-1:0]     STROBE_EDGE,
  output logic              FAIL,
  output logic [N_PINS-1:0] FAIL_MASK
`endif
);

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d, cl_q, cl_d, le_q, le_d, te_q, te_d;
  logic [CW-1:0]     ncyc_q, ncyc_d, cnt_q, cnt_d;
  logic [N_PINS-1:0] f0_q, f0_d, f1_q, f1_d, oe_q, oe_d;
  logic [N_PINS-1:0] stage_q, stage_d, act_q, act_d;
  logic              stage_vld_q, stage_vld_d, stop_seen_q, stop_seen_d;
  logic              done_q, done_d, underrun_q, underrun_d;
  logic              overflow_q, overflow_d, cfg_err_q, cfg_err_d;
  logic              start_ok, cyc_end, run_end, in_run;

  assign start_ok = START && (state_q == ST_IDLE);
  assign in_run   = (state_q == ST_RUN);
  assign cyc_end  = in_run && (t_q == cl_q - TW'(1));
  assign run_end  = ((ncyc_q != '0) && (cnt_q + CW'(1) == ncyc_q)) || stop_seen_q || STOP;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    cl_d        = cl_q;
    le_d        = le_q;
    te_d        = te_q;
    ncyc_d      = ncyc_q;
    cnt_d       = cnt_q;
    f0_d        = f0_q;
    f1_d        = f1_q;
    oe_d        = oe_q;
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    act_d       = act_q;
    stop_seen_d = stop_seen_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;
    cfg_err_d   = cfg_err_q;

    // START clears status first so a same-cycle overflow still sticks.
    if (start_ok) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
      cfg_err_d  = 1'b0;
      cnt_d      = '0;
    end

    if (LOAD && LOAD_SEL == SEL_VEC) begin
      if (!stage_vld_q) begin
        stage_d     = BUS;
        stage_vld_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (LOAD && state_q == ST_IDLE) begin
      case (LOAD_SEL)
        SEL_FMT0: f0_d = BUS;
        SEL_FMT1: f1_d = BUS;
        SEL_OE:   oe_d = BUS;
        default:  ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (CYCLE_LENGTH < TW'(2)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = ST_ARM;
            cl_d        = CYCLE_LENGTH;
            le_d        = LEADING_EDGE;
            te_d        = TRAILING_EDGE;
            ncyc_d      = NUM_CYCLES;
            stop_seen_d = 1'b0;
          end
        end
      end
      ST_ARM: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (stage_vld_q) begin
          act_d       = stage_q;
          stage_vld_d = 1'b0;
          t_d         = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (STOP) stop_seen_d = 1'b1;
        if (cyc_end) begin
          t_d = '0;
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          if (run_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (stage_vld_q) begin
            act_d       = stage_q;
            stage_vld_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      cl_q        <= '0;
      le_q        <= '0;
      te_q        <= '0;
      ncyc_q      <= '0;
      cnt_q       <= '0;
      f0_q        <= '0;
      f1_q        <= '0;
      oe_q        <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      act_q       <= '0;
      stop_seen_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cl_q        <= cl_d;
      le_q        <= le_d;
      te_q        <= te_d;
      ncyc_q      <= ncyc_d;
      cnt_q       <= cnt_d;
      f0_q        <= f0_d;
      f1_q        <= f1_d;
      oe_q        <= oe_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      act_q       <= act_d;
      stop_seen_q <= stop_seen_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // t never reaches cl_q, so an edge programmed at or beyond the cycle length never matches.
  logic t0_ev, le_ev, te_ev;
  assign t0_ev = in_run && (t_q == '0);
  assign le_ev = in_run && (t_q == le_q);
  assign te_ev = in_run && (t_q == te_q);

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    dut_pin_fmt u_fmt (
      .clk   (CLK),
      .rst_n (RST),
      .d     (act_q[i]),
      .fmt   (fmt_e'({f1_q[i], f0_q[i]})),
      .t0_ev (t0_ev),
      .le_ev (le_ev),
      .te_ev (te_ev),
      .q     (PIN_OUT[i])
    );
  end

  assign PIN_OE    = (state_q == ST_IDLE) ? '0 : oe_q;
  assign VEC_READY = ~stage_vld_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign CYCLE_CNT = cnt_q;
  assign UNDERRUN  = underrun_q;
  assign OVERFLOW  = overflow_q;
  assign CFG_ERR   = cfg_err_q;

`ifdef DUTSEQ_CAPTURE_EN
  // Undriven pins are compared against the active data bit at the strobe phase.
  logic [TW-1:0]     strobe_q, strobe_d;
  logic              fail_q, fail_d;
  logic [N_PINS-1:0] fail_mask_q, fail_mask_d, mism;

  always_comb begin
    strobe_d    = strobe_q;
    fail_d      = fail_q;
    fail_mask_d = fail_mask_q;
    mism        = (PIN_IN ^ act_q) & ~oe_q;
    if (start_ok) begin
      strobe_d    = STROBE_EDGE;
      fail_d      = 1'b0;
      fail_mask_d = '0;
    end else if (in_run && t_q == strobe_q) begin
      fail_mask_d = fail_mask_q | mism;
      fail_d      = fail_q | (|mism);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strobe_q    <= '0;
      fail_q      <= 1'b0;
      fail_mask_q <= '0;
    end else begin
      strobe_q    <= strobe_d;
      fail_q      <= fail_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign FAIL      = fail_q;
  assign FAIL_MASK = fail_mask_q;
`endif

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed bench for dut_vector_sequencer with an expected-waveform scoreboard.
// Latency: expected PIN_OUT values queued per RUN clock, compared one per clock.
// Backpressure: n/a.
module tb_dut_vector_sequencer;

  localparam int NP = 8;
  localparam int TW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] bus;
  logic          load;
  logic [1:0]    load_sel;
  logic          vec_ready;
  logic [TW-1:0] le, te, cl;
  logic [CW-1:0] ncyc;
  logic          start, stop;
  logic [NP-1:0] pin_out, pin_oe;
  logic          busy, done;
  logic [CW-1:0] cycle_cnt;
  logic          underrun, overflow, cfg_err;
`ifdef DUTSEQ_CAPTURE_EN
  logic [NP-1:0] pin_in;
  logic [TW-1:0] strobe;
  logic          fail;
  logic [NP-1:0] fail_mask;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  logic [7:0] vecs[2];

  always #5 clk = ~clk;

  dut_vector_sequencer #(.N_PINS(NP), .TW(TW), .CW(CW)) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .BUS          (bus),
    .LOAD         (load),
    .LOAD_SEL     (load_sel),
    .VEC_READY    (vec_ready),
    .LEADING_EDGE (le),
    .TRAILING_EDGE(te),
    .CYCLE_LENGTH (cl),
    .NUM_CYCLES   (ncyc),
    .START        (start),
    .STOP         (stop),
    .PIN_OUT      (pin_out),
    .PIN_OE       (pin_oe),
    .BUSY         (busy),
    .DONE         (done),
    .CYCLE_CNT    (cycle_cnt),
    .UNDERRUN     (underrun),
    .OVERFLOW     (overflow),
    .CFG_ERR      (cfg_err)
`ifdef DUTSEQ_CAPTURE_EN
    ,
    .PIN_IN       (pin_in),
    .STROBE_EDGE  (strobe),
    .FAIL         (fail),
    .FAIL_MASK    (fail_mask)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [1:0] sel, input logic [7:0] v);
    load = 1'b1; load_sel = sel; bus = v;
    tick();
    load = 1'b0;
  endtask

  // START then one ARM clock; returns at phase t=0 of the first RUN cycle.
  task automatic start_run(input int c, input int l, input int t, input int n, input logic [7:0] oe_exp);
    cl = TW'(c); le = TW'(l); te = TW'(t); ncyc = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_arm", 32'(busy), 32'd1);
    check("oe_arm", 32'(pin_oe), 32'(oe_exp));
    tick();
  endtask

  task automatic run(input int nclk, input int load_at, input logic [7:0] lv, input int stop_at);
    for (int i = 0; i < nclk; i++) begin
      check($sformatf("pin_out[%0d]", i), 32'(pin_out), 32'(exp_q.pop_front()));
      load = (i == load_at); load_sel = 2'd0; bus = lv;
      stop = (i == stop_at);
      tick();
    end
    load = 1'b0;
    stop = 1'b0;
  endtask

  task automatic end_check(input int cnt_exp);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("cycle_cnt", 32'(cycle_cnt), 32'(cnt_exp));
    check("oe_idle", 32'(pin_oe), 32'd0);
    tick();
    check("done_low", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; load_sel = '0; bus = '0;
    le = '0; te = '0; cl = '0; ncyc = '0; start = 1'b0; stop = 1'b0;
`ifdef DUTSEQ_CAPTURE_EN
    pin_in = '0; strobe = '0;
`endif
    repeat (2) tick();
    check("rst_pin_out", 32'(pin_out), 32'd0);
    check("rst_pin_oe", 32'(pin_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_vec_ready", 32'(vec_ready), 32'd1);
    check("rst_flags", {29'd0, underrun, overflow, cfg_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // RZ run, two vectors, two cycles.
    load_word(2'd1, 8'hFF); load_word(2'd2, 8'h00); load_word(2'd3, 8'hFF);
    load_word(2'd0, 8'hA5);
    check("vec_ready_full", 32'(vec_ready), 32'd0);
    vecs[0] = 8'hA5; vecs[1] = 8'h3C;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 10; k++)
        exp_q.push_back((k >= 3 && k <= 6) ? vecs[c] : 8'h00);
    start_run(10, 2, 6, 2, 8'hFF);
    check("vec_ready_after_xfer", 32'(vec_ready), 32'd1);
    run(20, 0, 8'h3C, -1);
    check("rz_underrun", 32'(underrun), 32'd0);
    end_check(2);

    // SBC on pins 0 (d=1) and 2 (d=0), R1 on pin 1 (d=0), NRZ on pin 7 (d=1).
    load_word(2'd1, 8'h05); load_word(2'd2, 8'h07);
    load_word(2'd0, 8'h81);
    for (int k = 0; k < 10; k++) begin
      e = '0;
      e[0] = (k >= 3 && k <= 6);
      e[1] = (k >= 7);
      e[2] = (k >= 1 && k <= 2) || (k >= 7);
      e[7] = (k >= 3);
      exp_q.push_back(e);
    end
    start_run(10, 2, 6, 1, 8'hFF);
    run(10, -1, 8'h00, -1);
    end_check(1);

    // Overflow on a second load, then underrun repeats the only vector.
    load_word(2'd1, 8'hFF); load_word(2'd2, 8'h00);
    load_word(2'd0, 8'hA5);
    load_word(2'd0, 8'h3C);
    check("overflow_set", 32'(overflow), 32'd1);
    check("vec_ready_ovf", 32'(vec_ready), 32'd0);
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 10; k++)
        exp_q.push_back((k >= 3 && k <= 6) ? 8'hA5 : ((c == 0 && k < 3) ? 8'h86 : 8'h00));
    start_run(10, 2, 6, 2, 8'hFF);
    run(20, -1, 8'h00, -1);
    check("underrun_set", 32'(underrun), 32'd1);
    check("overflow_cleared", 32'(overflow), 32'd0);
    end_check(2);

    // Cycle length below two is rejected.
    cl = TW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    check("cfg_busy", 32'(busy), 32'd0);
    check("cfg_underrun_clr", 32'(underrun), 32'd0);
    tick();
    check("cfg_busy_later", 32'(busy), 32'd0);

    // LE = TE with RZ: trailing action wins, pin stays low.
    load_word(2'd0, 8'hFF);
    for (int k = 0; k < 10; k++) exp_q.push_back(8'h00);
    start_run(10, 4, 4, 1, 8'hFF);
    check("cfg_err_cleared", 32'(cfg_err), 32'd0);
    run(10, -1, 8'h00, -1);
    end_check(1);

    // TE beyond cycle length never fires.
    load_word(2'd0, 8'hA5);
    for (int k = 0; k < 10; k++) exp_q.push_back((k >= 3) ? 8'hA5 : 8'h00);
    start_run(10, 2, 12, 1, 8'hFF);
    run(10, -1, 8'h00, -1);
    end_check(1);

    // Free-run stopped mid-cycle: the cycle completes.
    load_word(2'd0, 8'h3C);
    for (int k = 0; k < 10; k++)
      exp_q.push_back((k < 3) ? 8'hA5 : ((k <= 6) ? 8'h3C : 8'h00));
    start_run(10, 2, 6, 0, 8'hFF);
    run(10, -1, 8'h00, 4);
    end_check(1);

    // STOP in ARM aborts with no DONE; staged vector stays put.
    load_word(2'd0, 8'hFF);
    cl = TW'(10); le = TW'(2); te = TW'(6); ncyc = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("arm_stop_busy", 32'(busy), 32'd0);
    check("arm_stop_done", 32'(done), 32'd0);
    check("arm_stop_vec_ready", 32'(vec_ready), 32'd0);
    tick();
    check("arm_stop_done_later", 32'(done), 32'd0);

    // Reset asserted mid-run clears everything immediately.
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 10; k++)
        if (c * 10 + k < 14) exp_q.push_back((k >= 3 && k <= 6) ? 8'hFF : 8'h00);
    start_run(10, 2, 6, 0, 8'hFF);
    run(14, -1, 8'h00, -1);
    check("pre_rst_pin_out", 32'(pin_out), 32'hFF);
    check("pre_rst_cnt", 32'(cycle_cnt), 32'd1);
    check("pre_rst_underrun", 32'(underrun), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pin_out", 32'(pin_out), 32'd0);
    check("mid_rst_pin_oe", 32'(pin_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
    check("mid_rst_flags", {29'd0, underrun, overflow, cfg_err}, 32'd0);
    check("mid_rst_vec_ready", 32'(vec_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef DUTSEQ_CAPTURE_EN
    // Pin 3 undriven, expects 1, sees 0 at the strobe phase.
    load_word(2'd3, 8'hF7);
    load_word(2'd0, 8'h08);
    strobe = TW'(5); pin_in = '0;
    start_run(10, 2, 6, 1, 8'hF7);
    repeat (10) tick();
    check("fail_mask", 32'(fail_mask), 32'h08);
    check("fail", 32'(fail), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
